// File: rtl/counter_user_gen.sv
// Prescaled up/down terminal counter for the Genius game datapath.
// Emits a one-cycle tc_o on each terminal step and latches done_o in one-shot mode.
//
//   state | meaning
//   RUN   | qualified e_i pulses advance the prescaler and the count
//   HOLD  | one-shot finished; count, prescaler and done_o frozen until clr_i/r_i
module counter_user_gen #(
  parameter int N   = 4,
  parameter int DIV = 1
) (
  input  logic         clk_i,
  input  logic         r_i,
  input  logic         clr_i,
  input  logic         e_i,
  input  logic         dir_i,
  input  logic         mode_i,
  input  logic [N-1:0] data_i,
  output logic [N-1:0] count_o,
  output logic         tc_o,
  output logic         done_o
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(DIV - 1);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  count_q, count_d;
  logic [PW-1:0] psc_q, psc_d;
  logic          tc_q, tc_d;
  logic          done_q, done_d;
  logic          step;
  logic          term;

  assign step = e_i && (psc_q == PSC_LAST);
  assign term = dir_i ? (count_q == '0) : (count_q == data_i);

  always_ff @(posedge clk_i or negedge r_i) begin
    if (!r_i) begin
      state_q <= RUN;
      count_q <= '0;
      psc_q   <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      psc_q   <= psc_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    psc_d   = psc_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    if (clr_i) begin
      state_d = RUN;
      count_d = dir_i ? data_i : '0;
      psc_d   = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (step) begin
            psc_d = '0;
            if (!term) begin
              count_d = dir_i ? (count_q - 1'b1) : (count_q + 1'b1);
            end else if (!mode_i) begin
              tc_d    = 1'b1;
              count_d = dir_i ? data_i : '0;
            end else begin
              // one-shot parks on the terminal value
              tc_d    = 1'b1;
              done_d  = 1'b1;
              state_d = HOLD;
            end
          end else if (e_i) begin
            psc_d = psc_q + PW'(1);
          end
        end
        HOLD: begin
          done_d = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign done_o  = done_q;

endmodule

// File: doc/counter_user_gen.md
Name: counter_user_gen

Overview:
- Parametrised successor of the user-press counter for the Genius game datapath.
- Counts qualified enable pulses against a runtime terminal value, then emits a one-cycle terminal pulse.
- Adds generic width, an enable prescaler, up/down direction, auto-reload/one-shot mode, synchronous clear and a visible count.
- Sits between the button-edge logic and the game FSM; the FSM uses tc_o/done_o to decide when a round or sequence is complete.

Parameters:
- N, 4, width of count_o and data_i.
- DIV, 1, number of qualified e_i cycles per count step. Legal range 1..65535. DIV=1 means every e_i is a step.

Ports:
- clk_i  in  1  system clock, rising edge.
- r_i  in  1  reset, asynchronous, active-low. Low forces reset state immediately.
- clr_i  in  1  synchronous clear/restart.
- e_i  in  1  enable pulse, sampled each rising edge.
- dir_i  in  1  0 = count up (start 0, terminal data_i); 1 = count down (start data_i, terminal 0).
- mode_i  in  1  0 = auto-reload; 1 = one-shot.
- data_i  in  N  terminal value (up) or reload value (down), unsigned.
- count_o  out  N  current count, registered.
- tc_o  out  1  terminal pulse, registered, high exactly one cycle per terminal step.
- done_o  out  1  one-shot finished flag, level.

Behaviour:
- Reset (r_i low, async): count_o=0, tc_o=0, done_o=0, prescaler=0, state RUN. This applies in both directions.
- Priority each edge: reset > clr_i > step.
- clr_i=1:
  - count_o = 0 if dir_i=0, data_i if dir_i=1.
  - prescaler=0, tc_o=0, done_o=0, state RUN.
  - e_i is ignored in that cycle.
- Prescaler: an internal counter of ceil(log2(DIV)) bits, minimum 1 bit.
  - Increments on each e_i=1 in RUN.
  - A step occurs on the edge where e_i=1 and prescaler==DIV-1; the prescaler then returns to 0.
  - e_i=0 holds the prescaler.
- States:
  - RUN: steps are processed as below.
  - HOLD: entered only in one-shot. count_o, prescaler and done_o=1 are frozen; e_i, dir_i, mode_i and data_i changes are ignored; tc_o=0. Exit only via clr_i or reset.
- Step in RUN, terminal test: count_o==data_i (dir_i=0) or count_o==0 (dir_i=1).
- Step, not terminal:
  - count_o +1 (up) or -1 (down), modulo 2^N.
  - tc_o=0.
- Step, terminal, mode_i=0:
  - tc_o=1 next cycle.
  - count_o reloads to the start value: 0 up, data_i down.
- Step, terminal, mode_i=1:
  - tc_o=1 next cycle and done_o=1 on the same edge.
  - count_o holds the terminal value; state goes to HOLD.
- tc_o is 0 in every cycle without a terminal step. It never stays high for two consecutive cycles unless a terminal step occurs on consecutive edges.
- Latency: count_o and tc_o update on the same edge the step is qualified. Steps are observable one cycle after e_i is sampled.
- dir_i, mode_i and data_i are sampled at each step edge. Changes mid-count take effect at the next step, with no reload.
- Boundaries:
  - data_i=0, up: every step is terminal, so tc_o fires each step and count_o stays 0.
  - data_i below count_o, up: count wraps 2^N-1 -> 0 and continues until it equals data_i.
  - Down mode after reset: count_o=0, so the first step is terminal.
  - Reset asserted mid-count or in HOLD: all outputs clear asynchronously. Release is synchronous to the next edge.

Test Plan:
- N=4, DIV=1, up, auto, data_i=3, e_i high 8 cycles -> count_o 1,2,3,0,1,2,3,0; tc_o high only after edges 4 and 8.
- Up, one-shot, data_i=2, e_i high 6 cycles -> tc_o one pulse after edge 3; count_o=2 held; done_o=1. Then clr_i -> count_o=0, done_o=0.
- Down, auto, data_i=5, clr_i, then 7 enables -> count_o 5,4,3,2,1,0, then tc_o pulse with count_o=5.
- DIV=3, up, data_i=1, e_i alternating 1/0 for 12 cycles (6 enables) -> count_o=1 after the 3rd enable; tc_o pulse after the 6th enable, count_o=0.
- Count 9, up, data_i changed to 4 -> count_o 10..15,0,1,2,3,4, then terminal pulse on the step from 4.
- count_o=2 mid-run, r_i low between clock edges -> count_o=0, tc_o=0, done_o=0 before the next edge. Same check from HOLD.
